// File: rtl/calc_core_if.sv
// Key-event input and display-side outputs of the calculator core.
interface calc_core_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] disp_data;
    logic        busy;
    logic        err;
    logic        op_pending;

    modport master (
        output key_valid, key_code,
        input  disp_data, busy, err, op_pending
    );

    modport slave (
        input  key_valid, key_code,
        output disp_data, busy, err, op_pending
    );
endinterface

// File: rtl/calc_core.sv
// Calculator core: operand entry, left-to-right + - * evaluation,
// shift-add multiplier and range checking for a 4-digit display.
module calc_core #(
    parameter int MAX_POS    = 9999,
    parameter int MIN_NEG    = -999,
    parameter int MAX_DIGITS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    calc_core_if.slave  bus
);

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_OP_WAIT,
        S_ENTRY_B,
        S_MUL,
        S_RESULT,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    localparam logic signed [16:0] L_MAX17 = 17'(MAX_POS);
    localparam logic signed [16:0] L_MIN17 = 17'(MIN_NEG);
    localparam logic signed [28:0] L_MAX29 = 29'(MAX_POS);
    localparam logic signed [28:0] L_MIN29 = 29'(MIN_NEG);
    localparam logic [2:0]         L_NDIG  = 3'(MAX_DIGITS);

    state_t             r_state;
    logic [13:0]        r_mag;
    logic               r_neg;
    logic [2:0]         r_ndig;
    logic signed [15:0] r_acc;
    op_t                r_op;
    logic               r_op_pending;
    logic               r_err;
    logic [27:0]        r_mcand;
    logic [13:0]        r_mplier;
    logic [27:0]        r_prod;
    logic [3:0]         r_cnt;
    logic               r_msign;
    op_t                r_mul_op;
    logic               r_mul_eq;

    state_t             w_nxt_state;
    logic [13:0]        w_nxt_mag;
    logic               w_nxt_neg;
    logic [2:0]         w_nxt_ndig;
    logic signed [15:0] w_nxt_acc;
    op_t                w_nxt_op;
    logic               w_nxt_op_pending;
    logic               w_nxt_err;
    logic [27:0]        w_nxt_mcand;
    logic [13:0]        w_nxt_mplier;
    logic [27:0]        w_nxt_prod;
    logic [3:0]         w_nxt_cnt;
    logic               w_nxt_msign;
    op_t                w_nxt_mul_op;
    logic               w_nxt_mul_eq;

    logic               w_key;
    logic               w_clr;
    logic               w_is_dig;
    logic               w_is_op;
    logic               w_is_eq;
    logic               w_is_sgn;
    op_t                w_key_op;

    logic signed [16:0] w_entry;
    logic signed [16:0] w_acc17;
    logic signed [16:0] w_opnd17;
    logic signed [16:0] w_addsub;
    logic signed [16:0] w_negacc;
    logic [13:0]        w_acc_abs;
    logic [13:0]        w_mul_b;
    logic               w_fresh;
    logic [13:0]        w_base_mag;
    logic               w_base_neg;
    logic [2:0]         w_base_ndig;
    logic [16:0]        w_dig_mag;
    logic               w_dig_ok;
    logic [27:0]        w_prod_add;
    logic signed [28:0] w_prod29;
    logic signed [28:0] w_mres;

    logic               w_eval;
    logic               w_apply;
    logic signed [28:0] w_res;
    logic               w_to_result;
    op_t                w_newop;

    assign w_key    = bus.key_valid && (r_state != S_MUL);
    assign w_clr    = w_key && (bus.key_code == 4'hE);
    assign w_is_dig = bus.key_code <= 4'd9;
    assign w_is_op  = (bus.key_code == 4'hA) ||
                      (bus.key_code == 4'hB) ||
                      (bus.key_code == 4'hC);
    assign w_is_eq  = bus.key_code == 4'hD;
    assign w_is_sgn = bus.key_code == 4'hF;

    always_comb begin
        w_key_op = OP_ADD;
        if (bus.key_code == 4'hB) w_key_op = OP_SUB;
        if (bus.key_code == 4'hC) w_key_op = OP_MUL;
    end

    assign w_entry  = r_neg ? -$signed({3'b000, r_mag})
                            :  $signed({3'b000, r_mag});
    assign w_acc17  = {r_acc[15], r_acc};
    assign w_negacc = -w_acc17;
    assign w_acc_abs = r_acc[15] ? (~r_acc[13:0] + 14'd1)
                                 : r_acc[13:0];

    // OP_WAIT evaluation uses the accumulator as both operands
    assign w_opnd17 = (r_state == S_OP_WAIT) ? w_acc17 : w_entry;
    assign w_mul_b  = (r_state == S_OP_WAIT) ? w_acc_abs : r_mag;
    assign w_addsub = (r_op == OP_SUB) ? (w_acc17 - w_opnd17)
                                       : (w_acc17 + w_opnd17);

    assign w_fresh     = (r_state == S_OP_WAIT) ||
                         (r_state == S_RESULT);
    assign w_base_mag  = w_fresh ? 14'd0 : r_mag;
    assign w_base_neg  = w_fresh ? 1'b0  : r_neg;
    assign w_base_ndig = w_fresh ? 3'd0  : r_ndig;
    assign w_dig_mag   = {3'b000, w_base_mag} * 17'd10
                       + {13'd0, bus.key_code};
    assign w_dig_ok    = (w_base_ndig < L_NDIG) &&
                         !(w_base_neg && (w_dig_mag > 17'd999));

    assign w_prod_add = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_prod29   = $signed({1'b0, r_prod});
    assign w_mres     = r_msign ? -w_prod29 : w_prod29;

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_mag        = r_mag;
        w_nxt_neg        = r_neg;
        w_nxt_ndig       = r_ndig;
        w_nxt_acc        = r_acc;
        w_nxt_op         = r_op;
        w_nxt_op_pending = r_op_pending;
        w_nxt_err        = r_err;
        w_nxt_mcand      = r_mcand;
        w_nxt_mplier     = r_mplier;
        w_nxt_prod       = r_prod;
        w_nxt_cnt        = r_cnt;
        w_nxt_msign      = r_msign;
        w_nxt_mul_op     = r_mul_op;
        w_nxt_mul_eq     = r_mul_eq;
        w_eval           = 1'b0;
        w_apply          = 1'b0;
        w_res            = '0;
        w_to_result      = 1'b0;
        w_newop          = r_op;

        if (r_state == S_MUL) begin
            if (r_cnt != 4'd14) begin
                w_nxt_prod   = w_prod_add;
                w_nxt_mcand  = r_mcand << 1;
                w_nxt_mplier = r_mplier >> 1;
                w_nxt_cnt    = r_cnt + 4'd1;
            end else begin
                w_apply     = 1'b1;
                w_res       = w_mres;
                w_to_result = r_mul_eq;
                w_newop     = r_mul_op;
            end
        end else if (w_key && (r_state != S_ERROR)) begin
            unique case (1'b1)
                w_is_dig: begin
                    if (w_dig_ok) begin
                        w_nxt_mag  = w_dig_mag[13:0];
                        w_nxt_neg  = w_base_neg;
                        w_nxt_ndig = w_base_ndig + 3'd1;
                    end
                    if (r_state == S_OP_WAIT) w_nxt_state = S_ENTRY_B;
                    if (r_state == S_RESULT)  w_nxt_state = S_ENTRY_A;
                end
                w_is_op: begin
                    case (r_state)
                        S_ENTRY_B: begin
                            w_eval  = 1'b1;
                            w_newop = w_key_op;
                        end
                        default: begin
                            if (r_state == S_ENTRY_A)
                                w_nxt_acc = w_entry[15:0];
                            w_nxt_op         = w_key_op;
                            w_nxt_op_pending = 1'b1;
                            w_nxt_state      = S_OP_WAIT;
                        end
                    endcase
                end
                w_is_eq: begin
                    case (r_state)
                        S_ENTRY_A: begin
                            w_nxt_acc        = w_entry[15:0];
                            w_nxt_op_pending = 1'b0;
                            w_nxt_state      = S_RESULT;
                        end
                        S_ENTRY_B, S_OP_WAIT: begin
                            w_eval      = 1'b1;
                            w_to_result = 1'b1;
                        end
                        default: ;
                    endcase
                end
                w_is_sgn: begin
                    case (r_state)
                        S_ENTRY_A, S_ENTRY_B: begin
                            if (r_neg || (r_mag <= 14'd999))
                                w_nxt_neg = ~r_neg;
                        end
                        S_RESULT: begin
                            if ((w_negacc <= L_MAX17) &&
                                (w_negacc >= L_MIN17))
                                w_nxt_acc = w_negacc[15:0];
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        // Multiply defers the result; add/sub resolve on this edge
        if (w_eval) begin
            if (r_op == OP_MUL) begin
                w_nxt_state  = S_MUL;
                w_nxt_mcand  = {14'd0, w_acc_abs};
                w_nxt_mplier = w_mul_b;
                w_nxt_prod   = '0;
                w_nxt_cnt    = 4'd0;
                w_nxt_msign  = r_acc[15] ^
                               ((r_state == S_OP_WAIT) ? r_acc[15] : r_neg);
                w_nxt_mul_op = w_newop;
                w_nxt_mul_eq = w_to_result;
            end else begin
                w_apply = 1'b1;
                w_res   = {{12{w_addsub[16]}}, w_addsub};
            end
        end

        if (w_apply) begin
            if ((w_res > L_MAX29) || (w_res < L_MIN29)) begin
                w_nxt_state      = S_ERROR;
                w_nxt_err        = 1'b1;
                w_nxt_op_pending = 1'b0;
                w_nxt_acc        = '0;
            end else begin
                w_nxt_acc        = w_res[15:0];
                w_nxt_op         = w_newop;
                w_nxt_op_pending = !w_to_result;
                w_nxt_state      = w_to_result ? S_RESULT : S_OP_WAIT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_state      <= S_ENTRY_A;
            r_mag        <= '0;
            r_neg        <= 1'b0;
            r_ndig       <= '0;
            r_acc        <= '0;
            r_op         <= OP_ADD;
            r_op_pending <= 1'b0;
            r_err        <= 1'b0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_prod       <= '0;
            r_cnt        <= '0;
            r_msign      <= 1'b0;
            r_mul_op     <= OP_ADD;
            r_mul_eq     <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_mag        <= w_nxt_mag;
            r_neg        <= w_nxt_neg;
            r_ndig       <= w_nxt_ndig;
            r_acc        <= w_nxt_acc;
            r_op         <= w_nxt_op;
            r_op_pending <= w_nxt_op_pending;
            r_err        <= w_nxt_err;
            r_mcand      <= w_nxt_mcand;
            r_mplier     <= w_nxt_mplier;
            r_prod       <= w_nxt_prod;
            r_cnt        <= w_nxt_cnt;
            r_msign      <= w_nxt_msign;
            r_mul_op     <= w_nxt_mul_op;
            r_mul_eq     <= w_nxt_mul_eq;
        end
    end

    always_comb begin
        bus.disp_data = '0;
        case (r_state)
            S_ENTRY_A, S_ENTRY_B: bus.disp_data = w_entry[15:0];
            S_OP_WAIT, S_RESULT, S_MUL: bus.disp_data = r_acc;
            default: bus.disp_data = '0;
        endcase
    end

    assign bus.busy       = (r_state == S_MUL);
    assign bus.err        = r_err;
    assign bus.op_pending = r_op_pending;

endmodule

// File: tb/tb_calc_core.sv
// Directed tests for calc_core: entry, add/sub, multiply timing,
// range errors, sign toggle and reset during multiply.
module tb_calc_core;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    calc_core_if bus ();

    calc_core dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.disp_data !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_disp: got %0d want 0", bus.disp_data);
        end
        n_checks++;
        if ({bus.busy, bus.err, bus.op_pending} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.busy, bus.err, bus.op_pending});
        end
    endtask

    task automatic test_digits();
        press(4'hE);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        n_checks++;
        if (bus.disp_data !== 16'd1234) begin
            n_errors++;
            $display("FAIL digit_cap: got %0d want 1234", $signed(bus.disp_data));
        end
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL digit_err: got %b want 0", bus.err);
        end
    endtask

    task automatic test_addsub();
        press(4'hE);
        press(4'd7); press(4'hA); press(4'd5); press(4'hD);
        n_checks++;
        if (bus.disp_data !== 16'd12) begin
            n_errors++;
            $display("FAIL add_result: got %0d want 12", $signed(bus.disp_data));
        end
        press(4'hB);
        n_checks++;
        if (bus.op_pending !== 1'b1) begin
            n_errors++;
            $display("FAIL sub_pending: got %b want 1", bus.op_pending);
        end
        press(4'd2); press(4'hD);
        n_checks++;
        if (bus.disp_data !== 16'd10) begin
            n_errors++;
            $display("FAIL sub_result: got %0d want 10", $signed(bus.disp_data));
        end
        n_checks++;
        if (bus.op_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL result_pending: got %b want 0", bus.op_pending);
        end
        press(4'hE);
        press(4'd5); press(4'hA); press(4'hD);
        n_checks++;
        if (bus.disp_data !== 16'd10) begin
            n_errors++;
            $display("FAIL opwait_eq: got %0d want 10", $signed(bus.disp_data));
        end
    endtask

    task automatic test_multiply();
        int n;
        press(4'hE);
        press(4'd1); press(4'd2); press(4'hC); press(4'd3); press(4'd4);
        press(4'hD);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            bus.key_valid = (n == 3);
            bus.key_code  = 4'd9;
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
        n_checks++;
        if (n !== 15) begin
            n_errors++;
            $display("FAIL mul_busy_len: got %0d want 15", n);
        end
        n_checks++;
        if (bus.disp_data !== 16'd408) begin
            n_errors++;
            $display("FAIL mul_result: got %0d want 408", $signed(bus.disp_data));
        end
        n_checks++;
        if (bus.op_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_pending: got %b want 0", bus.op_pending);
        end
        press(4'hE);
        press(4'd1); press(4'd2); press(4'hF); press(4'hC); press(4'd3);
        press(4'hD);
        wait_idle("mul_neg");
        n_checks++;
        if (bus.disp_data !== 16'hFFDC) begin
            n_errors++;
            $display("FAIL mul_neg: got %0d want -36", $signed(bus.disp_data));
        end
    endtask

    task automatic test_overflow();
        press(4'hE);
        press(4'd5); press(4'd0); press(4'd0); press(4'd0);
        press(4'hC); press(4'd3); press(4'hD);
        wait_idle("ovf");
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL mul_ovf: got err=%b disp=%0d want err=1 disp=0",
                     bus.err, $signed(bus.disp_data));
        end
        press(4'd9);
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL err_ignore: got err=%b disp=%0d want err=1 disp=0",
                     bus.err, $signed(bus.disp_data));
        end
        press(4'hE);
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b disp=%0d want err=0 disp=0",
                     bus.err, $signed(bus.disp_data));
        end
        press(4'd9); press(4'd9); press(4'd9); press(4'd8);
        press(4'hA); press(4'd1); press(4'hD);
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b0, 16'd9999}) begin
            n_errors++;
            $display("FAIL max_pos: got err=%b disp=%0d want err=0 disp=9999",
                     bus.err, $signed(bus.disp_data));
        end
        press(4'hA); press(4'd1); press(4'hD);
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL above_max: got err=%b disp=%0d want err=1 disp=0",
                     bus.err, $signed(bus.disp_data));
        end
    endtask

    task automatic test_sign();
        press(4'hE);
        press(4'd9); press(4'd9); press(4'd9); press(4'hF);
        n_checks++;
        if (bus.disp_data !== 16'hFC19) begin
            n_errors++;
            $display("FAIL neg_entry: got %0d want -999", $signed(bus.disp_data));
        end
        press(4'hB); press(4'd1); press(4'hD);
        n_checks++;
        if ({bus.err, bus.disp_data} !== {1'b1, 16'd0}) begin
            n_errors++;
            $display("FAIL below_min: got err=%b disp=%0d want err=1 disp=0",
                     bus.err, $signed(bus.disp_data));
        end
        press(4'hE);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hF);
        n_checks++;
        if (bus.disp_data !== 16'd1234) begin
            n_errors++;
            $display("FAIL sign_ignore: got %0d want 1234", $signed(bus.disp_data));
        end
        press(4'hE);
        press(4'd1); press(4'd0); press(4'd0); press(4'hF); press(4'd0);
        n_checks++;
        if (bus.disp_data !== 16'hFF9C) begin
            n_errors++;
            $display("FAIL neg_digit_cap: got %0d want -100", $signed(bus.disp_data));
        end
    endtask

    task automatic test_reset_mid_mul();
        press(4'hE);
        press(4'd1); press(4'd2); press(4'hC); press(4'd3); press(4'd4);
        press(4'hD);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.err, bus.op_pending, bus.disp_data} !==
            {3'b000, 16'd0}) begin
            n_errors++;
            $display("FAIL rst_mid_mul: got busy=%b disp=%0d want busy=0 disp=0",
                     bus.busy, $signed(bus.disp_data));
        end
        press(4'd3);
        n_checks++;
        if (bus.disp_data !== 16'd3) begin
            n_errors++;
            $display("FAIL after_rst_digit: got %0d want 3", $signed(bus.disp_data));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_digits();
        test_addsub();
        test_multiply();
        test_overflow();
        test_sign();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
